matrix_exec_sequencer: RTL and testbench
========================================

Name: matrix_exec_sequencer

Overview:
- Execute-stage sequencer directly upstream of the matrix ALU; also consumes the ALU's result.
- Accepts one decoded 32-bit matrix instruction (opcode::dest::src1::src2) and fetches the 256-bit operands over the shared unit bus.
- Issues the operands to the matrix ALU, waits for completion, then writes the 256-bit result back to the destination register/memory location.
- Also handles Stop (FFh), halt, and bus-timeout/illegal-opcode errors.

Parameters:
BUS_TIMEOUT, 64, max cycles waiting for bus_ack or alu_done before error
ALU_UNIT, 4'h3, value driven on bus_addr[15:12] is never this (ALU has a dedicated port); reserved for decode check

Ports:
Clk  input  1  clock, all state changes on rising edge
Reset  input  1  asynchronous active-high reset
instr_valid  input  1  instruction offered
instr_ready  output  1  sequencer can accept (IDLE only)
instr  input  32  [31:24] opcode, [23:16] dest, [15:8] src1, [7:0] src2
bus_addr  output  16  [15:12] unit select, [11:8] 0, [7:0] operand index
bus_rd  output  1  read request, held until bus_ack
bus_wr  output  1  write request, held until bus_ack
bus_wdata  output  256  write data (ALU result)
bus_rdata  input  256  read data, valid when bus_ack
bus_ack  input  1  one-cycle completion of rd/wr
alu_opcode  output  8  opcode to ALU
alu_src1  output  256  operand A
alu_src2  output  256  operand B
alu_start  output  1  one-cycle pulse, operands/opcode stable from this cycle until alu_done
alu_done  input  1  one-cycle pulse, alu_result valid
alu_result  input  256  ALU output
busy  output  1  high in any state except IDLE and HALT
halted  output  1  sticky after Stop
error  output  1  sticky after illegal opcode or timeout

Behaviour:
- Reset (async, any state): state=IDLE. All outputs 0 except instr_ready=1. Operand registers and timeout counter cleared. An in-flight bus/ALU transaction is abandoned without a write.
- Operand byte b maps to bus_addr = {b[7] ? 4'h1 (register) : 4'h0 (main mem), 4'h0, b}.
- States: IDLE -> DECODE -> RD_SRC1 -> RD_SRC2 -> ALU_ISSUE -> ALU_WAIT -> WR_DEST -> IDLE; plus HALT and ERR.
- IDLE: instr_ready=1. Handshake when instr_valid & instr_ready: latch instr, go to DECODE next cycle.
- DECODE (1 cycle):
  - FFh -> HALT.
  - 00h–04h -> RD_SRC1.
  - 05h (MScaleImm) -> RD_SRC1, with src2 = {248'b0, imm8}.
  - 03h (transpose) skips RD_SRC2; alu_src2 = 0.
  - Any other opcode -> ERR.
- RD_SRC1 / RD_SRC2:
  - bus_rd=1 with the operand address; on the bus_ack cycle, capture bus_rdata, drop bus_rd, advance.
  - Read latency = ack cycle; minimum 1 cycle per read.
- ALU_ISSUE: alu_start=1 for exactly one cycle; alu_opcode/src1/src2 held until ALU_WAIT exits.
- ALU_WAIT: on alu_done, capture alu_result into bus_wdata, go to WR_DEST.
- WR_DEST: bus_wr=1 at the dest address until bus_ack, then IDLE. instr_ready is re-asserted the cycle after the ack.
- Timeout:
  - Counter resets on each state entry and counts cycles in RD_*, ALU_WAIT and WR_DEST.
  - Reaching BUS_TIMEOUT with no ack/done -> ERR; drop rd/wr; nothing written.
- ERR (1 cycle): set error (sticky until Reset), return to IDLE. Subsequent instructions still execute.
- HALT: halted=1, instr_ready=0, busy=0. Only Reset exits.
- Bus priority and rules:
  - bus_rd and bus_wr are never high together.
  - A bus_ack with no request outstanding is ignored.
  - A stray alu_done outside ALU_WAIT is ignored.
- Min instruction time with 1-cycle acks and a 1-cycle ALU: 7 cycles from handshake to instr_ready.

Optional Feature:
- Macro: MATSEQ_RESULT_BYPASS_EN.
- Defined:
  - Keep last written dest byte plus its 256-bit value and a valid bit.
  - If src1 or src2 equals the cached dest byte, skip that bus read (0 cycles) and use the cached value.
  - The cache is invalidated by Reset or ERR.
- Undefined: every operand is read over the bus; no cache storage.

Test Plan:
- Madd 01h dest=81 src1=80 src2=01; memory returns A=all 16'h0002, B=all 16'h0003; ALU model returns all 16'h0005 -> bus_addr sequence 0x1080 rd, 0x0001 rd, 0x1081 wr with wdata all 16'h0005; instr_ready back 7 cycles after handshake.
- Mtranspose 03h -> exactly one read; alu_src2=0; alu_start pulses once; one write.
- MScaleImm 05h imm=07 -> one read; alu_src2=256'h7.
- Opcode 0x10 -> error=1, no bus_rd/bus_wr; next Madd completes normally with error still 1.
- src2 bus_ack withheld 64 cycles -> error=1, bus_rd drops, no write; same for alu_done withheld.
- Stop FF -> halted=1, instr_ready=0 despite instr_valid. Reset pulse mid-ALU_WAIT -> all outputs 0 immediately and instr_ready=1. With MATSEQ_RESULT_BYPASS_EN, a back-to-back instruction using src1 = previous dest issues no read for src1.

Source files
------------

// File: rtl/matrix_exec_sequencer.sv
// matrix_exec_sequencer: execute-stage sequencer in front of the matrix ALU.
// Fetches two 256-bit operands over the shared unit bus, issues them to the
// ALU, waits for the result and writes it back to the destination location.
// Handles Stop (FFh), illegal opcodes and bus/ALU timeouts.
// Optional feature: define MATSEQ_RESULT_BYPASS_EN to enable a one-entry
// result bypass that skips operand reads hitting the last written dest byte.
//
// Handshakes: instr_valid/instr_ready transfer on a rising edge where both are
// high. bus_rd/bus_wr are held with a stable bus_addr until the one-cycle
// bus_ack; ack is only honoured while a request is up. alu_start pulses once
// and the ALU operands stay stable until the one-cycle alu_done.
module matrix_exec_sequencer #(
    parameter int         BUS_TIMEOUT = 64,
    parameter logic [3:0] ALU_UNIT    = 4'h3
) (
    input  logic         Clk,
    input  logic         Reset,
    input  logic         instr_valid,
    output logic         instr_ready,
    input  logic [31:0]  instr,
    output logic [15:0]  bus_addr,
    output logic         bus_rd,
    output logic         bus_wr,
    output logic [255:0] bus_wdata,
    input  logic [255:0] bus_rdata,
    input  logic         bus_ack,
    output logic [7:0]   alu_opcode,
    output logic [255:0] alu_src1,
    output logic [255:0] alu_src2,
    output logic         alu_start,
    input  logic         alu_done,
    input  logic [255:0] alu_result,
    output logic         busy,
    output logic         halted,
    output logic         error,
    output logic [3:0]   state_dbg
);

    typedef enum logic [3:0] {
        S_IDLE      = 4'd0,
        S_DECODE    = 4'd1,
        S_RD_SRC1   = 4'd2,
        S_RD_SRC2   = 4'd3,
        S_ALU_ISSUE = 4'd4,
        S_ALU_WAIT  = 4'd5,
        S_WR_DEST   = 4'd6,
        S_HALT      = 4'd7,
        S_ERR       = 4'd8
    } state_t;

    localparam int CW = $clog2(BUS_TIMEOUT) + 1;

    state_t         state_q, state_next;
    logic [31:0]    instr_q;
    logic [255:0]   src1_q, src2_q, wdata_q;
    logic [CW-1:0]  cnt_q;
    logic           error_q;

    logic [7:0]     op, dst, s1, s2;
    logic           legal, one_src, addr_bad, need_rd2, counting, timeout;
    logic           hit1, hit2;
    logic [255:0]   bypass_data;

    // Unit select for an operand byte: bit 7 picks register file vs main memory.
    function automatic logic [3:0] unit_of(input logic [7:0] b);
        return b[7] ? 4'h1 : 4'h0;
    endfunction

    function automatic logic [15:0] addr_of(input logic [7:0] b);
        return {unit_of(b), 4'h0, b};
    endfunction

    assign op       = instr_q[31:24];
    assign dst      = instr_q[23:16];
    assign s1       = instr_q[15:8];
    assign s2       = instr_q[7:0];
    assign legal    = (op <= 8'h05);
    assign one_src  = (op == 8'h03) || (op == 8'h05);
    // The ALU has its own port, so an operand must never decode onto its unit.
    assign addr_bad = (unit_of(dst) == ALU_UNIT) || (unit_of(s1) == ALU_UNIT) ||
                      (!one_src && (unit_of(s2) == ALU_UNIT));
    assign need_rd2 = !one_src && !hit2;
    assign counting = (state_q == S_RD_SRC1) || (state_q == S_RD_SRC2) ||
                      (state_q == S_ALU_WAIT) || (state_q == S_WR_DEST);
    assign timeout  = (cnt_q == CW'(BUS_TIMEOUT - 1));

`ifdef MATSEQ_RESULT_BYPASS_EN
    logic         cache_valid;
    logic [7:0]   cache_byte;
    logic [255:0] cache_data;

    assign hit1        = cache_valid && (cache_byte == s1);
    assign hit2        = cache_valid && (cache_byte == s2) && !one_src;
    assign bypass_data = cache_data;

    // Remember the last completed write; any error or reset drops it.
    always_ff @(posedge Clk or posedge Reset) begin
        if (Reset) begin
            cache_valid <= 1'b0;
            cache_byte  <= '0;
            cache_data  <= '0;
        end else if (state_q == S_ERR) begin
            cache_valid <= 1'b0;
        end else if (state_q == S_WR_DEST && bus_ack) begin
            cache_valid <= 1'b1;
            cache_byte  <= dst;
            cache_data  <= wdata_q;
        end
    end
`else
    assign hit1        = 1'b0;
    assign hit2        = 1'b0;
    assign bypass_data = '0;
`endif

    // State register.
    always_ff @(posedge Clk or posedge Reset) begin
        if (Reset) state_q <= S_IDLE;
        else       state_q <= state_next;
    end

    // Next-state decode.
    always_comb begin
        state_next = state_q;
        case (state_q)
            S_IDLE:      if (instr_valid) state_next = S_DECODE;
            S_DECODE: begin
                if (op == 8'hFF)           state_next = S_HALT;
                else if (!legal || addr_bad) state_next = S_ERR;
                else if (!hit1)            state_next = S_RD_SRC1;
                else if (need_rd2)         state_next = S_RD_SRC2;
                else                       state_next = S_ALU_ISSUE;
            end
            S_RD_SRC1: begin
                if (bus_ack)      state_next = need_rd2 ? S_RD_SRC2 : S_ALU_ISSUE;
                else if (timeout) state_next = S_ERR;
            end
            S_RD_SRC2: begin
                if (bus_ack)      state_next = S_ALU_ISSUE;
                else if (timeout) state_next = S_ERR;
            end
            S_ALU_ISSUE:          state_next = S_ALU_WAIT;
            S_ALU_WAIT: begin
                if (alu_done)     state_next = S_WR_DEST;
                else if (timeout) state_next = S_ERR;
            end
            S_WR_DEST: begin
                if (bus_ack)      state_next = S_IDLE;
                else if (timeout) state_next = S_ERR;
            end
            S_HALT:               state_next = S_HALT;
            S_ERR:                state_next = S_IDLE;
            default:              state_next = S_IDLE;
        endcase
    end

    // Moore outputs from the current state.
    always_comb begin
        instr_ready = 1'b0;
        bus_rd      = 1'b0;
        bus_wr      = 1'b0;
        bus_addr    = '0;
        alu_start   = 1'b0;
        case (state_q)
            S_IDLE:      instr_ready = 1'b1;
            S_RD_SRC1: begin
                bus_rd   = 1'b1;
                bus_addr = addr_of(s1);
            end
            S_RD_SRC2: begin
                bus_rd   = 1'b1;
                bus_addr = addr_of(s2);
            end
            S_ALU_ISSUE: alu_start = 1'b1;
            S_WR_DEST: begin
                bus_wr   = 1'b1;
                bus_addr = addr_of(dst);
            end
            default: ;
        endcase
    end

    // Instruction latch and operand/result datapath.
    always_ff @(posedge Clk or posedge Reset) begin
        if (Reset) begin
            instr_q <= '0;
            src1_q  <= '0;
            src2_q  <= '0;
            wdata_q <= '0;
        end else begin
            case (state_q)
                S_IDLE: if (instr_valid) instr_q <= instr;
                S_DECODE: begin
                    if (hit1) src1_q <= bypass_data;
                    if (op == 8'h03)      src2_q <= '0;
                    else if (op == 8'h05) src2_q <= {248'b0, s2};
                    else if (hit2)        src2_q <= bypass_data;
                end
                S_RD_SRC1:  if (bus_ack)  src1_q  <= bus_rdata;
                S_RD_SRC2:  if (bus_ack)  src2_q  <= bus_rdata;
                S_ALU_WAIT: if (alu_done) wdata_q <= alu_result;
                default: ;
            endcase
        end
    end

    // Wait-cycle counter, restarted on every state change.
    always_ff @(posedge Clk or posedge Reset) begin
        if (Reset)                     cnt_q <= '0;
        else if (state_next != state_q) cnt_q <= '0;
        else if (counting)             cnt_q <= cnt_q + 1'b1;
    end

    // Sticky error flag, raised as the FSM enters ERR.
    always_ff @(posedge Clk or posedge Reset) begin
        if (Reset)                    error_q <= 1'b0;
        else if (state_next == S_ERR) error_q <= 1'b1;
    end

    assign busy       = (state_q != S_IDLE) && (state_q != S_HALT);
    assign halted     = (state_q == S_HALT);
    assign error      = error_q;
    assign alu_opcode = op;
    assign alu_src1   = src1_q;
    assign alu_src2   = src2_q;
    assign bus_wdata  = wdata_q;
    assign state_dbg  = state_q;

endmodule

// File: tb/tb_matrix_exec_sequencer.sv
// Directed bench for matrix_exec_sequencer with a behavioural bus memory
// (register unit returns lanes of 2, main memory lanes of 3) and an ALU model
// that adds the two operands lane by lane and answers one cycle after start.
module tb_matrix_exec_sequencer;

    logic         Clk = 1'b0;
    logic         Reset = 1'b1;
    logic         instr_valid = 1'b0;
    logic [31:0]  instr = '0;
    logic         instr_ready;
    logic [15:0]  bus_addr;
    logic         bus_rd, bus_wr;
    logic [255:0] bus_wdata;
    logic [255:0] bus_rdata = '0;
    logic         bus_ack = 1'b0;
    logic [7:0]   alu_opcode;
    logic [255:0] alu_src1, alu_src2;
    logic         alu_start;
    logic         alu_done = 1'b0;
    logic [255:0] alu_result = '0;
    logic         busy, halted, error;
    logic [3:0]   state_dbg;

    int checks = 0;
    int fails  = 0;

    // Bench-side model controls (written only by the stimulus block).
    logic        block_en   = 1'b0;
    logic [15:0] block_addr = '0;
    logic        hold_done  = 1'b0;

    // Responder/monitor state (written only by their own processes).
    logic         alu_pend   = 1'b0;
    int           start_cnt  = 0;
    int           blk_cycles = 0;
    int           both_cnt   = 0;
    logic [255:0] last_wdata = '0;
    logic [255:0] start_src2 = '0;
    logic [16:0]  obs_q[$];
    logic [16:0]  exp_q[$];

    matrix_exec_sequencer dut (
        .Clk(Clk), .Reset(Reset),
        .instr_valid(instr_valid), .instr_ready(instr_ready), .instr(instr),
        .bus_addr(bus_addr), .bus_rd(bus_rd), .bus_wr(bus_wr),
        .bus_wdata(bus_wdata), .bus_rdata(bus_rdata), .bus_ack(bus_ack),
        .alu_opcode(alu_opcode), .alu_src1(alu_src1), .alu_src2(alu_src2),
        .alu_start(alu_start), .alu_done(alu_done), .alu_result(alu_result),
        .busy(busy), .halted(halted), .error(error), .state_dbg(state_dbg)
    );

    // Clock
    always #5 Clk = ~Clk;

    function automatic logic [255:0] fill16(input logic [15:0] v);
        return {16{v}};
    endfunction

    function automatic logic [255:0] lane_add(input logic [255:0] a, input logic [255:0] b);
        logic [255:0] r;
        for (int i = 0; i < 16; i++) r[i*16 +: 16] = a[i*16 +: 16] + b[i*16 +: 16];
        return r;
    endfunction

    // Bus memory and ALU model, driven on the falling edge.
    always @(negedge Clk) begin
        bus_ack  = 1'b0;
        alu_done = 1'b0;
        if (Reset) begin
            alu_pend = 1'b0;
        end else begin
            if ((bus_rd || bus_wr) && !(bus_rd && block_en && bus_addr == block_addr)) begin
                bus_ack   = 1'b1;
                bus_rdata = (bus_addr[15:12] == 4'h1) ? fill16(16'h0002) : fill16(16'h0003);
            end
            if (alu_pend && !hold_done) begin
                alu_done   = 1'b1;
                alu_result = lane_add(alu_src1, alu_src2);
                alu_pend   = 1'b0;
            end
            if (alu_start) alu_pend = 1'b1;
        end
    end

    // Monitor: logs completed bus transactions as {wr, addr}, counts pulses.
    always begin
        @(negedge Clk);
        #2;
        if (bus_rd && bus_wr) both_cnt++;
        if (bus_rd && block_en && bus_addr == block_addr) blk_cycles++;
        if (alu_start) begin
            start_cnt++;
            start_src2 = alu_src2;
        end
        if (bus_ack && (bus_rd || bus_wr)) begin
            obs_q.push_back({bus_wr, bus_addr});
            if (bus_wr) last_wdata = bus_wdata;
        end
    end

    task automatic check(input string tag, input logic [255:0] obs, input logic [255:0] exp);
        checks++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic do_reset();
        @(negedge Clk);
        Reset = 1'b1;
        instr_valid = 1'b0;
        repeat (2) @(negedge Clk);
        Reset = 1'b0;
    endtask

    task automatic issue(input logic [31:0] word);
        @(negedge Clk);
        instr_valid = 1'b1;
        instr = word;
        @(posedge Clk);
        #1;
        instr_valid = 1'b0;
    endtask

    task automatic wait_ready(output int n);
        n = 0;
        do begin
            @(negedge Clk);
            n++;
        end while (!instr_ready && n < 300);
        if (n >= 300) check("ready_timeout", instr_ready, 1'b1);
    endtask

    // Compare transactions logged since 'base' against exp_q, then clear exp_q.
    task automatic check_trans(input string tag, input int base);
        check({tag, "_count"}, obs_q.size() - base, exp_q.size());
        for (int i = 0; i < exp_q.size(); i++)
            if (base + i < obs_q.size()) check({tag, "_txn"}, obs_q[base + i], exp_q[i]);
        exp_q.delete();
    endtask

    initial begin
        int n, ob, st, bc;
        logic [255:0] exp_w;

        do_reset();
        @(negedge Clk);
        check("reset_ctl", {instr_ready, busy, halted, error, bus_rd, bus_wr, alu_start}, 7'b1000000);
        check("reset_addr", bus_addr, 16'h0000);
        check("reset_src1", alu_src1, '0);

        // Madd 01: dest 81, src1 80 (register), src2 01 (memory).
        ob = obs_q.size(); st = start_cnt;
        issue(32'h01_81_80_01);
        wait_ready(n);
        check("madd_latency", n, 7);
        exp_q.push_back({1'b0, 16'h1080});
        exp_q.push_back({1'b0, 16'h0001});
        exp_q.push_back({1'b1, 16'h1081});
        check_trans("madd", ob);
        check("madd_wdata", last_wdata, fill16(16'h0005));
        check("madd_starts", start_cnt - st, 1);

        // Mtranspose 03: dest 82, src1 02 (memory); no second read.
        ob = obs_q.size(); st = start_cnt;
        issue(32'h03_82_02_55);
        wait_ready(n);
        exp_q.push_back({1'b0, 16'h0002});
        exp_q.push_back({1'b1, 16'h1082});
        check_trans("transpose", ob);
        check("transpose_src2", start_src2, '0);
        check("transpose_starts", start_cnt - st, 1);
        check("transpose_wdata", last_wdata, fill16(16'h0003));

        // MScaleImm 05: dest 83, src1 84 (register), imm 07.
        ob = obs_q.size();
        issue(32'h05_83_84_07);
        wait_ready(n);
        exp_q.push_back({1'b0, 16'h1084});
        exp_q.push_back({1'b1, 16'h1083});
        check_trans("scale", ob);
        check("scale_src2", start_src2, 256'h7);
        exp_w = fill16(16'h0002);
        exp_w[15:0] = 16'h0009;
        check("scale_wdata", last_wdata, exp_w);

        // Illegal opcode 10h: error, no bus traffic.
        check("pre_illegal_error", error, 1'b0);
        ob = obs_q.size(); st = start_cnt;
        issue(32'h10_81_80_01);
        wait_ready(n);
        check("illegal_error", error, 1'b1);
        check_trans("illegal", ob);
        check("illegal_starts", start_cnt - st, 0);

        // Next Madd still completes; error stays sticky.
        ob = obs_q.size();
        issue(32'h01_85_86_07);
        wait_ready(n);
        exp_q.push_back({1'b0, 16'h1086});
        exp_q.push_back({1'b0, 16'h0007});
        exp_q.push_back({1'b1, 16'h1085});
        check_trans("madd2", ob);
        check("madd2_wdata", last_wdata, fill16(16'h0005));
        check("madd2_error", error, 1'b1);

        // src2 read never acknowledged: 64 cycles of bus_rd, then error.
        do_reset();
        @(negedge Clk);
        check("reset2_error", error, 1'b0);
        block_en = 1'b1; block_addr = 16'h000A;
        ob = obs_q.size(); bc = blk_cycles;
        issue(32'h01_88_89_0A);
        wait_ready(n);
        check("rdto_error", error, 1'b1);
        check("rdto_cycles", blk_cycles - bc, 64);
        check("rdto_rd_low", {bus_rd, bus_wr}, 2'b00);
        exp_q.push_back({1'b0, 16'h1089});
        check_trans("rdto", ob);
        block_en = 1'b0;

        // alu_done withheld: error, no write.
        do_reset();
        hold_done = 1'b1;
        ob = obs_q.size(); st = start_cnt;
        issue(32'h01_8A_8B_0C);
        wait_ready(n);
        check("aluto_error", error, 1'b1);
        check("aluto_starts", start_cnt - st, 1);
        exp_q.push_back({1'b0, 16'h108B});
        exp_q.push_back({1'b0, 16'h000C});
        check_trans("aluto", ob);

        // Reset asserted while in ALU_WAIT: outputs clear at once, no write.
        do_reset();
        ob = obs_q.size();
        issue(32'h01_8D_8E_0D);
        repeat (10) @(negedge Clk);
        check("midwait_busy", busy, 1'b1);
        #2;
        Reset = 1'b1;
        #1;
        check("async_rst_ctl", {instr_ready, busy, halted, error, bus_rd, bus_wr, alu_start}, 7'b1000000);
        check("async_rst_src1", alu_src1, '0);
        check("async_rst_op", alu_opcode, 8'h00);
        hold_done = 1'b0;
        @(negedge Clk);
        Reset = 1'b0;
        repeat (4) @(negedge Clk);
        exp_q.push_back({1'b0, 16'h108E});
        exp_q.push_back({1'b0, 16'h000D});
        check_trans("midwait", ob);

        // Stop: halts, refuses further instructions.
        ob = obs_q.size();
        issue(32'hFF_00_00_00);
        @(negedge Clk);
        instr_valid = 1'b1;
        instr = 32'h01_81_80_01;
        repeat (5) @(negedge Clk);
        check("halt_ctl", {instr_ready, busy, halted, error}, 4'b0010);
        instr_valid = 1'b0;
        check_trans("halt", ob);

`ifdef MATSEQ_RESULT_BYPASS_EN
        // Back-to-back: src1 equals previous dest, served from the bypass.
        do_reset();
        issue(32'h01_90_91_0B);
        wait_ready(n);
        ob = obs_q.size();
        issue(32'h01_92_90_0C);
        wait_ready(n);
        exp_q.push_back({1'b0, 16'h000C});
        exp_q.push_back({1'b1, 16'h1092});
        check_trans("bypass", ob);
        check("bypass_wdata", last_wdata, fill16(16'h0008));
`endif

        check("rd_wr_exclusive", both_cnt, 0);

        $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
        $finish;
    end

endmodule
